// File: rtl/reg_wb_arbiter_if.sv
// reg_wb_arbiter_if: ALU/load result sources and register-file write port bundle.
interface reg_wb_arbiter_if;
   logic        alu_valid;
   logic        alu_ready;
   logic [4:0]  alu_rd;
   logic [31:0] alu_data;
   logic        mem_valid;
   logic        mem_ready;
   logic [4:0]  mem_rd;
   logic [31:0] mem_data;
   logic        rf_we;
   logic [4:0]  rf_waddr;
   logic [31:0] rf_wdata;
   logic [31:0] pending_mask;
   modport master (
      output alu_valid, alu_rd, alu_data, mem_valid, mem_rd, mem_data,
      input  alu_ready, mem_ready, rf_we, rf_waddr, rf_wdata, pending_mask
   );
   modport slave (
      input  alu_valid, alu_rd, alu_data, mem_valid, mem_rd, mem_data,
      output alu_ready, mem_ready, rf_we, rf_waddr, rf_wdata, pending_mask
   );
endinterface

// File: rtl/reg_wb_arbiter.sv
// reg_wb_arbiter: per-source writeback FIFOs round-robin arbitrated onto one register-file write port.
module reg_wb_arbiter #(
   parameter int DEPTH = 2
) (
   input logic             clk,
   input logic             rst,
   reg_wb_arbiter_if.slave bus
);
   localparam int AW = $clog2(DEPTH);
   logic [1:0][DEPTH-1:0] vld;
   logic [1:0][AW-1:0]    wp, rp;
   logic [4:0]            rd_q  [2][DEPTH];
   logic [31:0]           dat_q [2][DEPTH];
   logic [4:0]            in_rd  [2];
   logic [31:0]           in_dat [2];
   logic [1:0]            in_v, rdy, push, head, pop;
   logic                  last_alu, gnt_alu, gnt_mem, we_d;
   logic [4:0]            g_rd;
   logic [31:0]           g_dat, pend;
   // Index 0 is the ALU source, index 1 the load source.
   assign in_v      = {bus.mem_valid, bus.alu_valid};
   assign in_rd[0]  = bus.alu_rd;
   assign in_rd[1]  = bus.mem_rd;
   assign in_dat[0] = bus.alu_data;
   assign in_dat[1] = bus.mem_data;
   assign rdy[0]    = ~rst & ~&vld[0];
   assign rdy[1]    = ~rst & ~&vld[1];
   assign push      = in_v & rdy;
   assign head[0]   = vld[0][rp[0]];
   assign head[1]   = vld[1][rp[1]];
   assign gnt_mem   = head[1] & (~head[0] | last_alu);
   assign gnt_alu   = head[0] & ~gnt_mem;
   assign pop       = {gnt_mem, gnt_alu};
   assign g_rd      = rd_q[gnt_mem][rp[gnt_mem]];
   assign g_dat     = dat_q[gnt_mem][rp[gnt_mem]];
   assign we_d      = (gnt_mem | gnt_alu) && g_rd != 5'd0;
   assign bus.alu_ready = rdy[0];
   assign bus.mem_ready = rdy[1];
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         vld          <= '0;
         wp           <= '0;
         rp           <= '0;
         last_alu     <= 1'b1;
         bus.rf_we    <= 1'b0;
         bus.rf_waddr <= '0;
         bus.rf_wdata <= '0;
      end else begin
         for (int s = 0; s < 2; s++) begin
            if (push[s]) begin
               vld[s][wp[s]] <= 1'b1;
               wp[s]         <= wp[s] + AW'(1);
            end
            if (pop[s]) begin
               vld[s][rp[s]] <= 1'b0;
               rp[s]         <= rp[s] + AW'(1);
            end
         end
         if (|pop) last_alu <= gnt_alu;
         bus.rf_we    <= we_d;
         bus.rf_waddr <= we_d ? g_rd : 5'd0;
         bus.rf_wdata <= we_d ? g_dat : 32'd0;
      end
   end
   // Payload storage needs no reset: the valid bits gate every use.
   always_ff @(posedge clk) begin
      for (int s = 0; s < 2; s++) begin
         if (push[s]) begin
            rd_q[s][wp[s]]  <= in_rd[s];
            dat_q[s][wp[s]] <= in_dat[s];
         end
      end
   end
   always_comb begin
      pend = '0;
      for (int s = 0; s < 2; s++)
         for (int i = 0; i < DEPTH; i++)
            if (vld[s][i]) pend[rd_q[s][i]] = 1'b1;
      if (bus.rf_we) pend[bus.rf_waddr] = 1'b1;
      pend[0] = 1'b0;
   end
   assign bus.pending_mask = pend;
endmodule
